// File: rtl/profile_timer_pkg.sv
// Shared constants, state encoding and bus request type for the profiling timer sequencer.
package profile_timer_pkg;

  // Interval-timer slave register map (16-bit slave).
  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;
  localparam logic [2:0] TMR_SNAP_L   = 3'd4;
  localparam logic [2:0] TMR_SNAP_H   = 3'd5;

  localparam logic [15:0] CTRL_START_CONT = 16'h0006;  // START|CONT, irq off
  localparam logic [15:0] PERIOD_HALF_MAX = 16'hFFFF;

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_GAP, INIT_CTL, IDLE, SNAP, RD_L, RD_H, CAP, UPD
  } seq_state_e;

  typedef struct packed {
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
  } tmr_req_t;

  // Bus request driven while the FSM sits in state st.
  function automatic tmr_req_t bus_decode(seq_state_e st);
    tmr_req_t b;
    b.address    = TMR_STATUS;
    b.chipselect = 1'b0;
    b.write_n    = 1'b1;
    b.writedata  = 16'h0000;
    case (st)
      INIT_PL:  begin b.address = TMR_PERIOD_L; b.chipselect = 1'b1; b.write_n = 1'b0; b.writedata = PERIOD_HALF_MAX; end
      INIT_PH:  begin b.address = TMR_PERIOD_H; b.chipselect = 1'b1; b.write_n = 1'b0; b.writedata = PERIOD_HALF_MAX; end
      INIT_CTL: begin b.address = TMR_CONTROL;  b.chipselect = 1'b1; b.write_n = 1'b0; b.writedata = CTRL_START_CONT; end
      SNAP:     begin b.address = TMR_SNAP_L;   b.chipselect = 1'b1; b.write_n = 1'b0; end
      RD_L:     begin b.address = TMR_SNAP_L;   b.chipselect = 1'b1; end
      RD_H:     begin b.address = TMR_SNAP_H;   b.chipselect = 1'b1; end
      default:  ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/profile_sect_arb.sv
// Pending start/stop bookkeeping, lowest-index selection and legality check.
module profile_sect_arb
  import profile_timer_pkg::*;
#(
  parameter int NUM_SECT = 4,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [NUM_SECT-1:0] mark_start,
  input  logic [NUM_SECT-1:0] mark_stop,
  input  logic [NUM_SECT-1:0] active,
  input  logic                take,
  output logic                sel_valid,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                sel_stop,
  output logic                sel_legal
);

  logic [NUM_SECT-1:0] pend_start, pend_stop;
  logic [NUM_SECT-1:0] clr_start, clr_stop;

  // Pick the lowest section with work; an active section services stop first.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_SECT-1; i >= 0; i--) begin
      if (pend_start[i] || pend_stop[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    sel_stop  = active[sel_idx] ? pend_stop[sel_idx] : ~pend_start[sel_idx];
    sel_legal = (sel_stop == active[sel_idx]);
  end

  // The serviced (or dropped) bit is retired when the FSM takes it.
  always_comb begin
    clr_start = '0;
    clr_stop  = '0;
    if (take && sel_valid) begin
      if (sel_stop) clr_stop[sel_idx]  = 1'b1;
      else          clr_start[sel_idx] = 1'b1;
    end
  end

  // Pending bits: clear wins, a same-cycle marker re-arms a bit being retired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_start <= '0;
      pend_stop  <= '0;
    end else if (clear) begin
      pend_start <= '0;
      pend_stop  <= '0;
    end else begin
      pend_start <= (pend_start & ~clr_start) | mark_start;
      pend_stop  <= (pend_stop  & ~clr_stop)  | mark_stop;
    end
  end

endmodule

// File: rtl/profile_timer_sequencer.sv
// Drives an interval timer as a free-running 32-bit down-counter and turns
// section start/stop markers into snapshot reads, accumulating per-section cycles.
module profile_timer_sequencer
  import profile_timer_pkg::*;
#(
  parameter  int NUM_SECT = 4,
  parameter  int ACC_W    = 40,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_SECT-1:0] mark_start,
  input  logic [NUM_SECT-1:0] mark_stop,
  input  logic                clear,
  output logic [2:0]          tmr_address,
  output logic                tmr_chipselect,
  output logic                tmr_write_n,
  output logic [15:0]         tmr_writedata,
  input  logic [15:0]         tmr_readdata,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [ACC_W-1:0]    rd_acc,
  output logic [CNT_W-1:0]    rd_count,
  output logic [NUM_SECT-1:0] sect_active,
  output logic [NUM_SECT-1:0] err_seq,
  output logic                init_done
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e state, nxt;
  tmr_req_t   bus_q;
  logic       booted;
  logic       take, sel_valid, sel_stop, sel_legal;
  logic [SEL_W-1:0] sel_idx, cur_idx;
  logic       cur_stop, discard;
  logic [15:0] snap_lo, snap_hi;
  logic [31:0] snap, delta;
  logic [64:0] acc_sum;
  logic [ACC_W-1:0] acc_next;

  logic [NUM_SECT-1:0][ACC_W-1:0] acc;
  logic [NUM_SECT-1:0][CNT_W-1:0] cnt;
  logic [NUM_SECT-1:0][31:0]      stamp;
  logic [NUM_SECT-1:0]            active, err;

  profile_sect_arb #(.NUM_SECT(NUM_SECT), .IDX_W(SEL_W)) u_arb (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .mark_start(mark_start), .mark_stop(mark_stop), .active(active),
    .take(take), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .sel_stop(sel_stop), .sel_legal(sel_legal)
  );

  // Next state; INIT_PL holds one extra cycle so its write is issued after reset.
  always_comb begin
    nxt  = state;
    take = 1'b0;
    case (state)
      INIT_PL:  if (booted) nxt = INIT_PH;
      INIT_PH:  nxt = INIT_GAP;
      INIT_GAP: nxt = INIT_CTL;
      INIT_CTL: nxt = IDLE;
      IDLE: begin
        if (!clear && sel_valid) begin
          take = 1'b1;
          if (sel_legal) nxt = SNAP;
        end
      end
      SNAP:     nxt = RD_L;
      RD_L:     nxt = RD_H;
      RD_H:     nxt = CAP;
      CAP:      nxt = UPD;
      UPD:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // State and registered bus request (bus always reflects the current state).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT_PL;
      booted    <= 1'b0;
      bus_q     <= bus_decode(IDLE);
      init_done <= 1'b0;
    end else begin
      state  <= nxt;
      booted <= 1'b1;
      bus_q  <= bus_decode(nxt);
      if (state == INIT_CTL) init_done <= 1'b1;
    end
  end

  assign tmr_address    = bus_q.address;
  assign tmr_chipselect = bus_q.chipselect;
  assign tmr_write_n    = bus_q.write_n;
  assign tmr_writedata  = bus_q.writedata;

  // Elapsed cycles for a down-counter with a 2^32 period: plain modulo subtract.
  always_comb begin
    snap     = {snap_hi, snap_lo};
    delta    = stamp[cur_idx] - snap;
    acc_sum  = 65'(acc[cur_idx]) + 65'(delta);
    acc_next = (acc_sum > 65'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
  end

  // Snapshot capture, error flags and per-section result update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo  <= '0;
      snap_hi  <= '0;
      cur_idx  <= '0;
      cur_stop <= 1'b0;
      discard  <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      stamp    <= '0;
      active   <= '0;
      err      <= '0;
    end else begin
      if (state == RD_H) snap_lo <= tmr_readdata;
      if (state == CAP)  snap_hi <= tmr_readdata;
      if (take && sel_legal) begin
        cur_idx  <= sel_idx;
        cur_stop <= sel_stop;
      end
      // A clear seen while a transaction is in flight voids its result.
      if (take)       discard <= 1'b0;
      else if (clear) discard <= 1'b1;
      if (clear) begin
        acc    <= '0;
        cnt    <= '0;
        active <= '0;
        err    <= '0;
      end else begin
        if (take && !sel_legal) err[sel_idx] <= 1'b1;
        if (state == UPD && !discard) begin
          if (cur_stop) begin
            acc[cur_idx]    <= acc_next;
            if (cnt[cur_idx] != CNT_MAX) cnt[cur_idx] <= cnt[cur_idx] + CNT_W'(1);
            active[cur_idx] <= 1'b0;
          end else begin
            stamp[cur_idx]  <= snap;
            active[cur_idx] <= 1'b1;
          end
        end
      end
    end
  end

  assign sect_active = active;
  assign err_seq     = err;

  // Readback mux; out-of-range selects read as zero.
  always_comb begin
    rd_acc   = '0;
    rd_count = '0;
    if (int'(rd_sel) < NUM_SECT) begin
      rd_acc   = acc[rd_sel];
      rd_count = cnt[rd_sel];
    end
  end

endmodule

// File: tb/tb_profile_timer_sequencer.sv
// Self-checking bench: behavioural interval timer plus an event-level reference
// model where elapsed time is the cycle distance between marker pulses.
module tb_profile_timer_sequencer;
  localparam int NS = 4;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
  logic [NS-1:0] mark_start = '0, mark_stop = '0;
  logic [2:0] tmr_address;
  logic tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata, tmr_readdata;
  logic [1:0] rd_sel = '0;
  logic [AW-1:0] rd_acc;
  logic [CW-1:0] rd_count;
  logic [NS-1:0] sect_active, err_seq;
  logic init_done;

  always #5 clk = ~clk;

  profile_timer_sequencer #(.NUM_SECT(NS), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .mark_start(mark_start), .mark_stop(mark_stop),
    .clear(clear), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
    .rd_sel(rd_sel), .rd_acc(rd_acc), .rd_count(rd_count), .sect_active(sect_active),
    .err_seq(err_seq), .init_done(init_done)
  );

  int cyc = 0;
  // Free-running edge counter used as the time base.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural timer: 32-bit down counter, snapshot on write to snap_l, registered reads.
  logic [31:0] t_cnt = 32'h0, t_snap = 32'h0, force_val = 32'h0;
  logic t_run = 1'b0, force_req = 1'b0;
  logic [15:0] t_rd = 16'h0;
  int wl_a[$], wl_d[$], wl_c[$], snapq[$];
  int rd5_cnt = 0;
  assign tmr_readdata = t_rd;

  // Timer slave behaviour and bus transaction logging.
  always @(posedge clk) begin
    if (force_req)  t_cnt <= force_val;
    else if (t_run) t_cnt <= t_cnt - 32'd1;
    if (tmr_chipselect && !tmr_write_n) begin
      wl_a.push_back(int'(tmr_address));
      wl_d.push_back(int'(tmr_writedata));
      wl_c.push_back(cyc);
      if (tmr_address == 3'd4) begin
        t_snap <= t_cnt;
        snapq.push_back(cyc);
      end
      if (tmr_address == 3'd1) t_run <= tmr_writedata[2];
    end
    if (tmr_chipselect && tmr_write_n && tmr_address == 3'd5) rd5_cnt <= rd5_cnt + 1;
    case (tmr_address)
      3'd4:    t_rd <= t_snap[15:0];
      3'd5:    t_rd <= t_snap[31:16];
      default: t_rd <= 16'h0;
    endcase
  end

  // Watchdog so the run always terminates.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state.
  longint m_acc[NS];
  int     m_cnt[NS], m_t0[NS];
  bit     m_act[NS], m_err[NS];

  task automatic model_mark(input bit stop, input int s, input int t);
    if (!stop) begin
      if (m_act[s]) m_err[s] = 1'b1;
      else begin m_act[s] = 1'b1; m_t0[s] = t; end
    end else begin
      if (!m_act[s]) m_err[s] = 1'b1;
      else begin
        m_acc[s] += longint'(t - m_t0[s]);
        if (m_acc[s] > ACC_MAX) m_acc[s] = ACC_MAX;
        if (m_cnt[s] < 65535) m_cnt[s]++;
        m_act[s] = 1'b0;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_act[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait so that a following pulse() is sampled on edge number target.
  task automatic wait_until(input int target);
    while (cyc < target - 2) @(negedge clk);
  endtask

  // One-cycle marker; t is the edge count at which the DUT samples it.
  task automatic pulse(input bit stop, input int s, output int t);
    @(negedge clk);
    if (stop) mark_stop[s] = 1'b1; else mark_start[s] = 1'b1;
    @(negedge clk);
    mark_stop = '0; mark_start = '0;
    t = cyc;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  task automatic check_sect(input int s);
    rd_sel = 2'(s);
    #1;
    chk($sformatf("acc%0d", s), 64'(rd_acc), 64'(m_acc[s]));
    chk($sformatf("cnt%0d", s), 64'(rd_count), 64'(m_cnt[s]));
    chk($sformatf("act%0d", s), 64'(sect_active[s]), 64'(m_act[s]));
    chk($sformatf("err%0d", s), 64'(err_seq[s]), 64'(m_err[s]));
  endtask

  initial begin
    int c0, t, t2, ns0, r5;
    bit st;
    int s;
    model_clear();
    repeat (3) @(negedge clk);
    // Reset state
    #1;
    chk("rst_cs", 64'(tmr_chipselect), 64'd0);
    chk("rst_wn", 64'(tmr_write_n), 64'd1);
    chk("rst_addr", 64'(tmr_address), 64'd0);
    chk("rst_init", 64'(init_done), 64'd0);
    chk("rst_act", 64'(sect_active), 64'd0);
    chk("rst_err", 64'(err_seq), 64'd0);
    chk("rst_acc", 64'(rd_acc), 64'd0);
    @(negedge clk);
    c0 = cyc;
    reset_n = 1'b1;

    // Init sequence: PL, PH, gap, CTL; init_done after the fifth edge
    idle(4); #1;
    chk("init_done_c4", 64'(init_done), 64'd0);
    idle(1); #1;
    chk("init_done_c5", 64'(init_done), 64'd1);
    chk("init_nwr", 64'(wl_a.size()), 64'd3);
    if (wl_a.size() >= 3) begin
      chk("init_w0", {32'(wl_a[0]), 32'(wl_d[0])}, {32'd2, 32'hFFFF});
      chk("init_w1", {32'(wl_a[1]), 32'(wl_d[1])}, {32'd3, 32'hFFFF});
      chk("init_w2", {32'(wl_a[2]), 32'(wl_d[2])}, {32'd1, 32'h0006});
      chk("init_c0", 64'(wl_c[0] - c0), 64'd1);
      chk("init_c1", 64'(wl_c[1] - c0), 64'd2);
      chk("init_c2", 64'(wl_c[2] - c0), 64'd4);
    end

    // Section 0: one 1000-cycle interval
    pulse(0, 0, t); model_mark(0, 0, t);
    idle(8); check_sect(0);
    wait_until(t + 1000);
    pulse(1, 0, t2); model_mark(1, 0, t2);
    idle(8); check_sect(0);
    chk("acc0_1000", 64'(rd_acc), 64'd1000);

    // Section 1 across the 32-bit counter wrap
    @(negedge clk); force_val = 32'h10; force_req = 1'b1;
    @(negedge clk); force_req = 1'b0;
    pulse(0, 1, t); model_mark(0, 1, t);
    wait_until(t + 100);
    pulse(1, 1, t2); model_mark(1, 1, t2);
    idle(8); check_sect(1);
    chk("acc1_wrap", 64'(rd_acc), 64'd100);

    // Simultaneous starts on sections 1 and 2: serviced in order, 6 cycles apart
    ns0 = snapq.size();
    @(negedge clk); mark_start = 4'b0110;
    @(negedge clk); mark_start = '0; t = cyc;
    model_mark(0, 1, t); model_mark(0, 2, t + 6);
    idle(14);
    chk("dual_nsnap", 64'(snapq.size() - ns0), 64'd2);
    if (snapq.size() >= ns0 + 2) chk("dual_gap", 64'(snapq[ns0+1] - snapq[ns0]), 64'd6);
    check_sect(1); check_sect(2);
    pulse(1, 1, t); model_mark(1, 1, t); idle(10);
    pulse(1, 2, t); model_mark(1, 2, t); idle(10);
    check_sect(1); check_sect(2);

    // Section 3: stop while inactive, then double start
    ns0 = snapq.size();
    pulse(1, 3, t); model_mark(1, 3, t);
    idle(8);
    chk("illegal_nosnap", 64'(snapq.size()), 64'(ns0));
    check_sect(3);
    pulse(0, 3, t); model_mark(0, 3, t); idle(10);
    pulse(0, 3, t); model_mark(0, 3, t); idle(10);
    pulse(1, 3, t); model_mark(1, 3, t); idle(10);
    check_sect(3);

    // Saturation of the 12-bit accumulator
    do_clear();
    for (int i = 0; i < NS; i++) check_sect(i);
    for (int k = 0; k < 2; k++) begin
      pulse(0, 0, t); model_mark(0, 0, t);
      wait_until(t + 3000);
      pulse(1, 0, t2); model_mark(1, 0, t2);
      idle(8);
    end
    check_sect(0);
    chk("sat_acc", 64'(rd_acc), 64'hFFF);
    chk("sat_cnt", 64'(rd_count), 64'd2);

    // Clear while a start transaction is in flight
    r5 = rd5_cnt;
    pulse(0, 0, t); model_mark(0, 0, t);
    do_clear();
    idle(10);
    chk("clr_busdone", 64'(rd5_cnt - r5), 64'd1);
    for (int i = 0; i < NS; i++) check_sect(i);

    // Randomized uncontended markers
    for (int k = 0; k < 60; k++) begin
      s  = int'($urandom_range(0, NS-1));
      st = 1'($urandom_range(0, 1));
      pulse(st, s, t); model_mark(st, s, t);
      idle(int'($urandom_range(8, 40)));
      check_sect(s);
    end
    for (int i = 0; i < NS; i++) check_sect(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
